btn_press_classifier: RTL

- Downstream stage of the button debouncer/test chain. Consumes one debounced button level and classifies each press as short or long.
- While a long press is held, it issues periodic repeat pulses.
- It also keeps a wrapping count of short presses.
- Its single-cycle event pulses drive the pet-control FSM. Examples: short press = select, long press = reset or test-mode entry.

---
 rtl/btn_press_classifier.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/btn_press_classifier.sv
// Classifies debounced button presses as short or long, emits repeat pulses
// while a long press is held, and keeps a wrapping count of short presses.
module btn_press_classifier #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LONG_MS   = 5000,
  parameter int unsigned REPEAT_MS = 500,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             count_clr,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_W     = $clog2(LONG_MS + 1);
  localparam int unsigned REP_W    = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;
  localparam int unsigned REP_LAST = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
  localparam bit          REP_EN   = (REPEAT_MS > 0);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESSED   = 2'd1;
  localparam logic [1:0] LONG_HOLD = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             sync_q1;
  logic             btn_s;
  logic [PRE_W-1:0] presc;
  logic [MS_W-1:0]  ms_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             tick_c;
  logic             ms_last_c;
  logic             rep_hit_c;
  logic             short_nxt;
  logic             long_nxt;
  logic             repeat_nxt;
  logic             held_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Two-flop synchronizer; the FSM only ever looks at btn_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      btn_s   <= sync_q1;
    end
  end

  assign tick_c    = (state != IDLE) && (presc == PRE_W'(TICK_DIV - 1));
  assign ms_last_c = (ms_cnt == MS_W'(LONG_MS - 1));
  assign rep_hit_c = REP_EN && (state == LONG_HOLD) && tick_c &&
                     (rep_cnt == REP_W'(REP_LAST));

  // Prescaler and ms counter idle at zero, so every entry to PRESSED starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (state == IDLE) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      presc <= tick_c ? '0 : presc + PRE_W'(1);
      if (state == PRESSED && tick_c) begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (state != LONG_HOLD || !REP_EN) begin
      rep_cnt <= '0;
    end else if (tick_c) begin
      rep_cnt <= rep_hit_c ? '0 : rep_cnt + REP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Release is checked first in each held state so it beats a coincident tick.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else if (tick_c && ms_last_c) begin
          state_nxt = LONG_HOLD;
          long_nxt  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (rep_hit_c) begin
          repeat_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    held_nxt = (state_nxt == LONG_HOLD);
    if (count_clr) begin
      count_nxt = '0;
    end else if (short_nxt) begin
      count_nxt = press_count + CNT_W'(1);
    end else begin
      count_nxt = press_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
      press_count  <= '0;
    end else begin
      short_pulse  <= short_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      held         <= held_nxt;
      press_count  <= count_nxt;
    end
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({short_pulse, long_pulse, repeat_pulse}));
  a_long_held: assert property (@(posedge clk) disable iff (rst)
    long_pulse |-> held);

endmodule
